// File: rtl/sfifo_lvl_if.sv
// Push/pop handshake bundle for sfifo_lvl.
// master = producer/consumer side, slave = the FIFO.
interface sfifo_lvl_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic          we;
    logic [DW-1:0] wd;
    logic          full;
    logic          almost_full;
    logic          re;
    logic [DW-1:0] rd;
    logic          empty;
    logic          almost_empty;
    logic [CW-1:0] count;

    modport master (
        output we, wd, re,
        input  full, almost_full, rd,
        input  empty, almost_empty, count
    );

    modport slave (
        input  we, wd, re,
        output full, almost_full, rd,
        output empty, almost_empty, count
    );
endinterface

// File: rtl/sfifo_lvl.sv
// Flip-flop FIFO, any depth >= 2, with level flags and flush.
// RZ_LIB_SFIFO_ERR_EN adds sticky overflow/underflow outputs.
module sfifo_lvl #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [CW-1:0] af_level,
    input  logic [CW-1:0] ae_level,
`ifdef RZ_LIB_SFIFO_ERR_EN
    output logic          overflow,
    output logic          underflow,
`endif
    sfifo_lvl_if.slave    bus
);

    localparam logic [CW-1:0] FULLC = CW'(DEPTH);
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign pop_ok  = bus.re & (cnt != '0);
    assign push_ok = bus.we & ((cnt != FULLC) | pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok & ~flush)
            mem[wptr] <= bus.wd;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok)
                wptr <= inc(wptr);
            if (pop_ok)
                rptr <= inc(rptr);
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef RZ_LIB_SFIFO_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (bus.we & ~push_ok)
                overflow <= 1'b1;
            if (bus.re & (cnt == '0))
                underflow <= 1'b1;
        end
    end
`endif

    assign bus.rd           = mem[rptr];
    assign bus.count        = cnt;
    assign bus.full         = (cnt == FULLC);
    assign bus.empty        = (cnt == '0);
    assign bus.almost_full  = (cnt >= af_level);
    assign bus.almost_empty = (cnt <= ae_level);

endmodule

// File: tb/tb_sfifo_lvl.sv
// Directed + random bench for sfifo_lvl, DEPTH=5, DW=8.
// Reference is a byte queue with occupancy rules.
module tb_sfifo_lvl;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [CW-1:0] af_level;
    logic [CW-1:0] ae_level;
`ifdef RZ_LIB_SFIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    sfifo_lvl_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    sfifo_lvl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .af_level (af_level),
        .ae_level (ae_level),
`ifdef RZ_LIB_SFIFO_ERR_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    int            checks = 0;
    int            passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, ".count"}, 32'(bus.count), n);
        chk({tag, ".empty"}, 32'(bus.empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(bus.full), 32'(n == DEPTH));
        chk({tag, ".af"}, 32'(bus.almost_full), 32'(n >= int'(af_level)));
        chk({tag, ".ae"}, 32'(bus.almost_empty), 32'(n <= int'(ae_level)));
        if (n != 0)
            chk({tag, ".rd"}, 32'(bus.rd), 32'(q[0]));
`ifdef RZ_LIB_SFIFO_ERR_EN
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow), 32'(m_unf));
`endif
    endtask

    task automatic model_clear();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the model, sample 1ns after the edge.
    task automatic step(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit f, input string tag);
        bit pop;
        bit push;
        bus.we = w;
        bus.wd = d;
        bus.re = r;
        flush  = f;
        @(posedge clk);
        pop  = r && q.size() > 0;
        push = w && (q.size() < DEPTH || pop);
        if (f) begin
            model_clear();
        end else begin
            if (w && !push) m_ovf = 1'b1;
            if (r && q.size() == 0) m_unf = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
        flush  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        bus.we   = 1'b0;
        bus.wd   = '0;
        bus.re   = 1'b0;
        af_level = 3'd0;
        ae_level = 3'd1;
        model_clear();
        #2;
        check_all("reset_af0");
        af_level = 3'd4;
        #1;
        check_all("reset_af4");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill and drain
        for (int i = 0; i < 5; i++)
            step(1, 8'(8'h10 + i), 0, 0, "fill");
        chk("fill.full_const", 32'(bus.full), 1);
        for (int i = 0; i < 5; i++)
            step(0, 0, 1, 0, "drain");
        chk("drain.empty_const", 32'(bus.empty), 1);

        // Wrap-around
        for (int i = 0; i < 3; i++) step(1, 8'(8'h20 + i), 0, 0, "wrap_p3");
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "wrap_r3");
        for (int i = 0; i < 5; i++) step(1, 8'(8'h30 + i), 0, 0, "wrap_p5");

        // Push on full with pop, then push-only on full
        step(1, 8'hAA, 1, 0, "pof_pp");
        chk("pof.count5", 32'(bus.count), 5);
        step(1, 8'hBB, 0, 0, "pof_ovf");
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, "pof_drain");

        // Thresholds
        af_level = 3'd4;
        ae_level = 3'd1;
        for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, "thr_push");
        chk("thr.af_const", 32'(bus.almost_full), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, "thr_pop");
        chk("thr.ae_const", 32'(bus.almost_empty), 1);

        // Flush with push, three entries held
        step(1, 8'h50, 0, 0, "fl_fill");
        step(1, 8'h51, 0, 0, "fl_fill");
        step(1, 8'h77, 0, 1, "flush");
        chk("flush.empty_const", 32'(bus.empty), 1);

        // Underflow
        step(0, 0, 1, 0, "underflow");
        step(1, 8'h61, 0, 0, "post_unf");
        step(1, 8'h62, 0, 0, "post_unf");

        // Async reset between edges
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check_all("async_rst");
        #1;
        reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                af_level = 3'($urandom_range(0, 6));
                ae_level = 3'($urandom_range(0, 6));
            end
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
                 "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sfifo_lvl.md
# sfifo_lvl

Synchronous single-clock FIFO built from flip-flops, generalised over the basic FF FIFO.
- Supports any depth ≥ 2, including non-power-of-two depths.
- Adds an occupancy count, run-time almost-full/almost-empty thresholds, synchronous flush and same-cycle push-on-full.
- Used as the standard elastic buffer between streaming pipeline stages in the same clock domain.

## Interface
Parameters:
- DW, 8, data width in bits.
- DEPTH, 4, number of entries; any integer ≥ 2.
- AW, $clog2(DEPTH), pointer width.
- CW, $clog2(DEPTH+1), count/threshold width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- flush  in  1  synchronous clear of pointers, count and error flags.
- we  in  1  push request.
- wd  in  DW  push data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ af_level.
- re  in  1  pop request.
- rd  out  DW  head-of-queue data (show-ahead).
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ ae_level.
- count  out  CW  current occupancy, 0..DEPTH.
- af_level  in  CW  almost-full threshold, quasi-static.
- ae_level  in  CW  almost-empty threshold, quasi-static.
- overflow  out  1  sticky; present only with RZ_LIB_SFIFO_ERR_EN.
- underflow  out  1  sticky; present only with RZ_LIB_SFIFO_ERR_EN.

## Operation
- State:
  - wptr, rptr: AW bits each, range 0..DEPTH-1.
  - count: CW bits.
  - mem: DEPTH × DW; not reset.
- Pointer increment wraps: DEPTH-1 → 0. No reliance on power-of-two rollover.
- Accepted pop (pop_ok) = re & (count != 0).
- Accepted push (push_ok) = we & ((count != DEPTH) | pop_ok).
  - A push while full is accepted only if a pop is accepted in the same cycle.
- On push_ok: mem[wptr] ← wd; wptr advances.
- On pop_ok: rptr advances.
- count update:
  - +1 on push_ok only.
  - −1 on pop_ok only.
  - Unchanged when both or neither occur.
- Push and pop together while empty: pop ignored, push accepted, count 0 → 1.
- rd = mem[rptr] combinationally. Valid whenever empty = 0; don't-care when empty.
- full, empty, almost_full and almost_empty decode combinationally from count and the threshold inputs.
- flush has priority over push and pop:
  - wptr, rptr and count go to 0; error flags are cleared.
  - A push presented in the flush cycle is dropped.
  - mem contents are untouched.
- reset: same clearing as flush, applied asynchronously.

## Timing
- Reset values:
  - count = 0, empty = 1, full = 0, almost_empty = 1.
  - almost_full = (af_level == 0).
  - overflow = underflow = 0.
  - rd is undefined.
- Push to visible: pushed data appears on rd, and count increments, in the cycle after the push edge. Zero-latency read of an empty FIFO is not supported.
- Pop: rd shows the next entry in the cycle after the pop edge.
- Flags change only on clock edges, or combinationally when the threshold inputs change.
- Simultaneous push and pop at any fill level 1..DEPTH: count holds. Throughput is 1 word/cycle sustained.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge. Deassertion is synchronised externally.

## Configuration
- Macro: RZ_LIB_SFIFO_ERR_EN.
- Defined:
  - overflow sets on we & ~push_ok (push rejected while full with no pop).
  - underflow sets on re & empty.
  - Both stick until reset or flush; flush wins over a same-cycle set.
- Undefined:
  - overflow and underflow ports and their logic are absent.
  - Rejected requests are silently ignored.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use DW = 8, DEPTH = 5 (non-power-of-two).

1. Fill and drain:
   - Reset, then push 0x10..0x14 on consecutive cycles → count 1..5, full = 1 after the fifth edge.
   - Pop 5 times → rd = 0x10..0x14 in order; empty = 1, count = 0.
2. Wrap-around: push 3, pop 3, then push 5 → wptr wraps 4 → 0; popped data intact, no gaps or duplicates.
3. Push on full: with the FIFO full, assert we+re with wd = 0xAA → count stays 5; 0xAA emerges fifth after the current head.
   - Same case with we only → data dropped; overflow = 1 (ERR_EN build).
4. Thresholds: af_level = 4, ae_level = 1.
   - Push 4 → almost_full rises on the fourth edge.
   - Pop 3 → almost_empty rises when count = 1.
5. Flush and reset:
   - Three entries held, flush + we asserted → next cycle count = 0, empty = 1, push dropped, error flags cleared.
   - Reset asserted between edges → outputs reach reset values without a clock edge.
6. Underflow: empty FIFO, re = 1 → count stays 0, rptr unchanged, underflow = 1 (ERR_EN build); no port present when the macro is undefined.
